ps2_key_tracker: RTL and testbench
==================================

# ps2_key_tracker

Parametrised successor to the single-byte keyboard mapper: consumes the scan-code byte stream from `PS2_Controller` and decodes full Set-2 sequences (make, `F0` break, `E0` extended, `E1` pause). It maintains a per-key held bitmap for a configurable key table, emits one-cycle make/break events, and keeps a last-pressed ASCII register. It sits between `PS2_Controller` and the paddle logic so that paddles move while keys are held, not per byte.

## Interface
- `NUM_KEYS`, 6, number of tracked keys (1..32).
- `KEY_CODES`, {9'h172,9'h042,9'h175,9'h044,9'h01B,9'h01D}, packed `NUM_KEYS`×9. Entry i = bits [9i+8:9i]; bit 8 = extended (`E0`) flag, bits 7:0 = code. Default order: idx0 W, 1 S, 2 O, 3 Up, 4 K, 5 Down.
- `KEY_ASCII`, {8'h4B,8'h4B,8'h4F,8'h4F,8'h53,8'h57}, packed `NUM_KEYS`×8, ASCII per entry.
- `IDLE_ASCII`, 8'h20, value loaded on an unmapped make.
- `TIMEOUT_CYCLES`, 50000, max cycles between bytes of one sequence (1 ms at 50 MHz).
- `inclock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `scan_code` in 8: byte from `PS2_Controller.received_data`.
- `scan_valid` in 1: one-cycle strobe, `PS2_Controller.received_data_en`.
- `key_held` out `NUM_KEYS`: bit i = 1 while entry i is held.
- `key_event` out 1: one-cycle pulse per decoded mapped make/break.
- `key_event_idx` out `$clog2(NUM_KEYS)` (min 1): entry index for `key_event`.
- `key_event_make` out 1: 1 = make, 0 = break; valid with `key_event`.
- `last_ascii` out 8: ASCII of the most recent make.

## Operation
- FSM states: `IDLE`, `EXT` (got `E0`), `BRK` (got `F0`), `EXT_BRK` (got `E0 F0`), `PAUSE` (skipping).
- `IDLE`: `E0`→`EXT`; `F0`→`BRK`; `E1`→`PAUSE` with skip count 7; any other byte = make of {0,byte}.
- `EXT`: `F0`→`EXT_BRK`; other byte = make of {1,byte}; back to `IDLE`.
- `BRK`: byte = break of {0,byte}. `EXT_BRK`: byte = break of {1,byte}. Both return to `IDLE`.
- `PAUSE`: each byte decrements the count; at 0 → `IDLE`. No events, no state change.
- Lookup: compare the 9-bit code against all entries. Every matching entry's `key_held` bit is set (make) or cleared (break). `key_event_idx` = lowest matching index.
- Mapped make: `last_ascii` ← `KEY_ASCII[idx]`. Unmapped make: `last_ascii` ← `IDLE_ASCII`, no event. Break never changes `last_ascii`. Unmapped break: no effect.
- Timeout: counter clears on each accepted byte and increments in any non-`IDLE` state. On reaching `TIMEOUT_CYCLES`: go to `IDLE`, discard the partial sequence. The counter is held at 0 in `IDLE`.

## Timing
- Reset: FSM `IDLE`, counter 0, `key_held` 0, `key_event` 0, `key_event_idx` 0, `key_event_make` 0, `last_ascii` 8'h00.
- All outputs registered. Latency from `scan_valid` of a final byte to `key_event`, `key_held` and `last_ascii` updates is 1 cycle.
- No backpressure: every `scan_valid` is consumed. Back-to-back strobes on consecutive cycles are legal.
- `scan_valid` in the same cycle the timeout expires: timeout wins, and the byte is decoded from `IDLE`.
- Reset asserted mid-sequence: immediate return to reset values, and all held keys are released without break events.

## Configuration
- `PS2_KEY_TRACKER_REPEAT_FILTER_EN` defined:
  - A make for an entry already held produces no `key_event` and does not update `last_ascii`. This suppresses typematic repeat.
  - A break for an entry not held produces no `key_event`.
- Undefined: every mapped make/break pulses `key_event`, and every mapped make updates `last_ascii`.
- `key_held` behaviour is identical in both builds.

## Structure
- `ps2_pkg`: FSM state enum; constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `PS2_PAUSE`=8'hE1, `PS2_PAUSE_TAIL`=7.
- Sub-module `ps2_key_match`: combinational. Inputs: 9-bit code and the `KEY_CODES` parameter. Outputs: hit vector, `any_hit` and lowest index. Everything else lives in `ps2_key_tracker`.

## Test plan
- Bytes `1D`, then `F0 1D` → `key_held`[0] 1 then 0. Events (idx0, make=1) then (idx0, make=0). `last_ascii`=8'h57 after the make and still 8'h57 after the break.
- `E0 75` then `E0 F0 75` → `key_held`[3] rises then falls. `last_ascii`=8'h4F. `key_held`[2] stays 0.
- `E1 14 77 E1 F0 14 F0 77`, then `1B` → no events during the pause sequence. Then `key_held`[1]=1 and `last_ascii`=8'h53.
- `E0`, idle for `TIMEOUT_CYCLES` cycles, then `1D` → decoded as non-extended W make, idx0.
- `1D 1D 1D` (typematic repeat) → filter build: 1 `key_event`. Unfiltered build: 3 `key_event` pulses. `key_held`[0]=1 in both.
- `1D 44`, then assert `reset` → `key_held`=6'b000101 before reset. After reset all outputs are 0 and `last_ascii`=8'h00. Unmapped `2A` afterwards → `last_ascii`=8'h20, no event.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Set-2 key tracker: decoder states and prefix bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;

endpackage

// File: rtl/ps2_key_match.sv
// Combinational key-table lookup: per-entry hit vector plus lowest matching index.
module ps2_key_match #(
  parameter int unsigned               NUM_KEYS  = 6,
  parameter int unsigned               IDX_W     = 3,
  parameter logic [NUM_KEYS*9-1:0]     KEY_CODES = '0
) (
  input  logic [8:0]          code,
  output logic [NUM_KEYS-1:0] hit,
  output logic                any_hit,
  output logic [IDX_W-1:0]    idx
);

  logic found;

  always_comb begin
    hit   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      hit[i] = (KEY_CODES[9*i +: 9] == code);
      if (hit[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    any_hit = |hit;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Set-2 scan-code sequence decoder with per-key held bitmap, make/break events and
// last-pressed ASCII. Define PS2_KEY_TRACKER_REPEAT_FILTER_EN to suppress typematic repeats.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned           NUM_KEYS       = 6,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h172, 9'h042, 9'h175, 9'h044, 9'h01B, 9'h01D},
  parameter logic [NUM_KEYS*8-1:0] KEY_ASCII      = {8'h4B, 8'h4B, 8'h4F, 8'h4F, 8'h53, 8'h57},
  parameter logic [7:0]            IDLE_ASCII     = 8'h20,
  parameter int unsigned           TIMEOUT_CYCLES = 50000,
  localparam int unsigned          IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                inclock,
  input  logic                reset,
  input  logic [7:0]          scan_code,
  input  logic                scan_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                key_event,
  output logic [IDX_W-1:0]    key_event_idx,
  output logic                key_event_make,
  output logic [7:0]          last_ascii
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t          state;
  ps2_state_t          dec_state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          skip;
  logic                expired;
  logic [8:0]          code;
  logic                do_make;
  logic                do_brk;
  logic                fresh_make;
  logic                fresh_brk;
  logic [NUM_KEYS-1:0] hit;
  logic                any_hit;
  logic [IDX_W-1:0]    hit_idx;

  ps2_key_match #(
    .NUM_KEYS  (NUM_KEYS),
    .IDX_W     (IDX_W),
    .KEY_CODES (KEY_CODES)
  ) u_match (
    .code    (code),
    .hit     (hit),
    .any_hit (any_hit),
    .idx     (hit_idx)
  );

  // A byte arriving in the cycle the timeout fires is decoded as if from IDLE.
  always_comb begin
    expired   = (state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYCLES));
    dec_state = expired ? IDLE : state;
    code      = {(dec_state == EXT) || (dec_state == EXT_BRK), scan_code};
    do_make   = 1'b0;
    do_brk    = 1'b0;
    if (scan_valid) begin
      case (dec_state)
        IDLE:         do_make = (scan_code != PS2_EXT) && (scan_code != PS2_BRK) &&
                                (scan_code != PS2_PAUSE);
        EXT:          do_make = (scan_code != PS2_BRK);
        BRK, EXT_BRK: do_brk  = 1'b1;
        default:      ;
      endcase
    end
`ifdef PS2_KEY_TRACKER_REPEAT_FILTER_EN
    fresh_make = ~key_held[hit_idx];
    fresh_brk  = key_held[hit_idx];
`else
    fresh_make = 1'b1;
    fresh_brk  = 1'b1;
`endif
  end

  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      skip           <= '0;
      key_held       <= '0;
      key_event      <= 1'b0;
      key_event_idx  <= '0;
      key_event_make <= 1'b0;
      last_ascii     <= '0;
    end else begin
      key_event <= 1'b0;
      if (scan_valid) begin
        cnt <= '0;
        case (dec_state)
          IDLE: begin
            if (scan_code == PS2_EXT)        state <= EXT;
            else if (scan_code == PS2_BRK)   state <= BRK;
            else if (scan_code == PS2_PAUSE) begin
              state <= PAUSE;
              skip  <= PS2_PAUSE_TAIL;
            end else                         state <= IDLE;
          end
          EXT:     state <= (scan_code == PS2_BRK) ? EXT_BRK : IDLE;
          PAUSE: begin
            skip <= skip - 3'd1;
            if (skip <= 3'd1) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (expired) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (do_make) begin
        key_held <= key_held | hit;
        if (!any_hit) begin
          last_ascii <= IDLE_ASCII;
        end else if (fresh_make) begin
          key_event      <= 1'b1;
          key_event_idx  <= hit_idx;
          key_event_make <= 1'b1;
          last_ascii     <= KEY_ASCII[8*hit_idx +: 8];
        end
      end else if (do_brk) begin
        key_held <= key_held & ~hit;
        if (any_hit && fresh_brk) begin
          key_event      <= 1'b1;
          key_event_idx  <= hit_idx;
          key_event_make <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker; expected events go to a scoreboard queue popped by a monitor.
module tb_ps2_key_tracker;

  localparam int unsigned T = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_code = '0;
  logic       scan_valid = 1'b0;
  logic [5:0] key_held;
  logic       key_event;
  logic [2:0] key_event_idx;
  logic       key_event_make;
  logic [7:0] last_ascii;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  ps2_key_tracker #(
    .NUM_KEYS       (6),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .inclock        (clk),
    .reset          (reset),
    .scan_code      (scan_code),
    .scan_valid     (scan_valid),
    .key_held       (key_held),
    .key_event      (key_event),
    .key_event_idx  (key_event_idx),
    .key_event_make (key_event_make),
    .last_ascii     (last_ascii)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input int make);
    exp_q.push_back(idx * 2 + make);
  endtask

  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    #1;
    chk(tag, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every event pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && key_event) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_event observed=idx%0d/make%0d expected=none", key_event_idx, key_event_make);
      end
      if (exp_q.size() > 0) begin
        int e;
        e = exp_q.pop_front();
        checks++;
        assert ({29'd0, key_event_idx, key_event_make} === 32'(e)) else begin
          errors++;
          $error("FAIL event observed=idx%0d/make%0d expected=idx%0d/make%0d",
                 key_event_idx, key_event_make, e / 2, e % 2);
        end
      end
    end
  end

  initial begin
    idle(3);
    chk("rst_held", key_held, 0);
    chk("rst_event", key_event, 0);
    chk("rst_idx", key_event_idx, 0);
    chk("rst_make", key_event_make, 0);
    chk("rst_ascii", last_ascii, 8'h00);
    reset = 1'b0;
    idle(2);

    push(0, 1); send(8'h1D);
    chk("w_make_held", key_held, 6'b000001);
    chk("w_make_ascii", last_ascii, 8'h57);
    push(0, 0); send(8'hF0); send(8'h1D);
    chk("w_brk_held", key_held, 6'b000000);
    chk("w_brk_ascii", last_ascii, 8'h57);
    drain("w_drain");

    push(3, 1); send(8'hE0); send(8'h75);
    chk("up_make_held", key_held, 6'b001000);
    chk("up_make_ascii", last_ascii, 8'h4F);
    push(3, 0); send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_brk_held", key_held, 6'b000000);
    chk("up_brk_ascii", last_ascii, 8'h4F);
    drain("up_drain");

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause_held", key_held, 6'b000000);
    chk("pause_ascii", last_ascii, 8'h4F);
    drain("pause_drain");
    push(1, 1); send(8'h1B);
    chk("s_make_held", key_held, 6'b000010);
    chk("s_make_ascii", last_ascii, 8'h53);

    send(8'hE0); idle(T);
    push(0, 1); send(8'h1D);
    chk("timeout_held", key_held, 6'b000011);
    chk("timeout_ascii", last_ascii, 8'h57);
    send(8'hE0); idle(T - 1);
    push(3, 1); send(8'h75);
    chk("pre_timeout_held", key_held, 6'b001011);
    chk("pre_timeout_ascii", last_ascii, 8'h4F);
    drain("timeout_drain");

    push(0, 0); send(8'hF0); send(8'h1D);
    push(3, 0); send(8'hE0); send(8'hF0); send(8'h75);
    push(1, 0); send(8'hF0); send(8'h1B);
    chk("release_held", key_held, 6'b000000);
    chk("release_ascii", last_ascii, 8'h4F);
    drain("release_drain");

    push(0, 1);
`ifndef PS2_KEY_TRACKER_REPEAT_FILTER_EN
    push(0, 1); push(0, 1);
`endif
    send(8'h1D); send(8'h1D); send(8'h1D);
    chk("repeat_held", key_held, 6'b000001);
    chk("repeat_ascii", last_ascii, 8'h57);
    drain("repeat_drain");

    push(2, 1); send(8'h44);
    chk("two_held", key_held, 6'b000101);
    chk("two_ascii", last_ascii, 8'h4F);
    drain("two_drain");

    send(8'hE0);
    reset = 1'b1;
    #1;
    chk("mid_rst_held", key_held, 0);
    chk("mid_rst_event", key_event, 0);
    chk("mid_rst_idx", key_event_idx, 0);
    chk("mid_rst_make", key_event_make, 0);
    chk("mid_rst_ascii", last_ascii, 8'h00);
    idle(2);
    reset = 1'b0;
    idle(1);

    send(8'h75);
    chk("post_rst_75_ascii", last_ascii, 8'h20);
    chk("post_rst_75_held", key_held, 0);
    send(8'h2A);
    chk("unmapped_ascii", last_ascii, 8'h20);
    drain("unmapped_drain");

`ifndef PS2_KEY_TRACKER_REPEAT_FILTER_EN
    push(0, 0);
`endif
    send(8'hF0); send(8'h1D);
    chk("stray_brk_held", key_held, 0);
    chk("stray_brk_ascii", last_ascii, 8'h20);
    idle(3);
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
